// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit for the E stage.
// Results are computed when an operation is launched and held in pending
// registers. They are committed to the architectural HI/LO registers once
// the busy countdown expires. mthi/mtlo write HI/LO directly when idle.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hiPend;
    logic [31:0] r_loPend;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;

    logic        w_launch;
    logic [3:0]  w_cycles;
    logic [31:0] w_hiNext;
    logic [31:0] w_loNext;
    logic [63:0] w_prodS;
    logic [63:0] w_prodU;
    logic        w_divZero;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [31:0] w_absBSafe;
    logic [31:0] w_divisorSafe;
    logic [31:0] w_qMag;
    logic [31:0] w_rMag;
    logic [31:0] w_qSigned;
    logic [31:0] w_rSigned;
    logic [31:0] w_qUnsigned;
    logic [31:0] w_rUnsigned;

    // Arithmetic datapath: products and quotients for the operands on the
    // inputs. Signed division works on magnitudes so that the most negative
    // dividend over -1 wraps to 0x80000000 instead of overflowing, and the
    // divisor is forced to 1 on zero so the dividers never see a zero.
    always_comb begin
        w_prodS       = $signed({{32{D1[31]}}, D1}) * $signed({{32{D2[31]}}, D2});
        w_prodU       = {32'd0, D1} * {32'd0, D2};
        w_divZero     = (D2 == 32'd0);
        w_absA        = D1[31] ? (32'd0 - D1) : D1;
        w_absB        = D2[31] ? (32'd0 - D2) : D2;
        w_absBSafe    = w_divZero ? 32'd1 : w_absB;
        w_divisorSafe = w_divZero ? 32'd1 : D2;
        w_qMag        = w_absA / w_absBSafe;
        w_rMag        = w_absA % w_absBSafe;
        w_qSigned     = (D1[31] ^ D2[31]) ? (32'd0 - w_qMag) : w_qMag;
        w_rSigned     = D1[31] ? (32'd0 - w_rMag) : w_rMag;
        w_qUnsigned   = D1 / w_divisorSafe;
        w_rUnsigned   = D1 % w_divisorSafe;
    end

    // Launch decode: pick the pending result and busy length for the op.
    // A divide by zero captures the current HI/LO so the commit is a no-op;
    // HI/LO cannot change while busy, so this equals keeping the old values.
    always_comb begin
        w_launch = 1'b0;
        w_cycles = 4'd0;
        w_hiNext = r_hi;
        w_loNext = r_lo;
        case (md_op)
            OP_MULT: begin
                w_launch = start;
                w_cycles = MULT_CNT;
                w_hiNext = w_prodS[63:32];
                w_loNext = w_prodS[31:0];
            end
            OP_MULTU: begin
                w_launch = start;
                w_cycles = MULT_CNT;
                w_hiNext = w_prodU[63:32];
                w_loNext = w_prodU[31:0];
            end
            OP_DIV: begin
                w_launch = start;
                w_cycles = DIV_CNT;
                if (!w_divZero) begin
                    w_hiNext = w_rSigned;
                    w_loNext = w_qSigned;
                end
            end
            OP_DIVU: begin
                w_launch = start;
                w_cycles = DIV_CNT;
                if (!w_divZero) begin
                    w_hiNext = w_rUnsigned;
                    w_loNext = w_qUnsigned;
                end
            end
            default: begin
                w_launch = 1'b0;
            end
        endcase
    end

    // Control FSM: launch, count down, and commit the pending result on the
    // last busy cycle; mthi/mtlo only take effect while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_hiPend <= 32'd0;
            r_loPend <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_hiPend <= w_hiNext;
                        r_loPend <= w_loNext;
                        r_cnt    <= w_cycles;
                        r_busy   <= 1'b1;
                        r_state  <= BUSY;
                    end else if (md_op == OP_MTHI) begin
                        r_hi <= D1;
                    end else if (md_op == OP_MTLO) begin
                        r_lo <= D1;
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd1) begin
                        r_hi    <= r_hiPend;
                        r_lo    <= r_loPend;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It accepts mult/multu/div/divu and mthi/mtlo from E, models a multi-cycle latency with a busy counter, and holds the architectural HI/LO registers. Its `busy` output, together with the E-stage `start` pulse, feeds the D-stage stall controller, which holds any HI/LO-using instruction in D while an operation is pending.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..15.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle launch strobe from E-stage decode, valid with `md_op` 1..4.
- `md_op`  in  3  operation code:
  - 0 none
  - 1 mult
  - 2 multu
  - 3 div
  - 4 divu
  - 5 mthi
  - 6 mtlo
  - 7 none
- `D1`  in  32  operand rs (forwarded value); dividend for div/divu; source for mthi/mtlo.
- `D2`  in  32  operand rt (forwarded value); divisor for div/divu.
- `busy`  out  1  operation in progress.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.

## Operation
- States: IDLE and BUSY. A 4-bit down-counter `cnt` and 32-bit pending registers `hi_p` and `lo_p`.
- **IDLE, `start`=1, `md_op` 1..4:**
  - Compute the result combinationally from D1/D2 and capture it into `hi_p`/`lo_p`.
  - Load `cnt` with MULT_CYCLES for mult/multu, or DIV_CYCLES for div/divu. Go to BUSY.
- **mult:** signed 32x32 to 64-bit product; HI = [63:32], LO = [31:0].
- **multu:** unsigned 32x32 to 64-bit product, same split.
- **div:** signed division. LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **divu:** unsigned division. LO = quotient, HI = remainder.
- **Divide by zero (div/divu, D2=0):** the unit still goes BUSY for DIV_CYCLES. At commit, HI and LO keep their previous values.
- **BUSY:** `cnt` decrements each cycle. On the edge where `cnt`=1, commit `hi_p`/`lo_p` into HI/LO and return to IDLE.
- **mthi/mtlo (md_op 5/6) in IDLE:** write D1 to HI (5) or LO (6) on that edge, independent of `start`. No busy period.
- **Ignored inputs:**
  - `start` or md_op 5/6 while BUSY: no effect on the in-flight operation. The stall controller prevents this case.
  - `start` with md_op 0, 5, 6 or 7: no launch.
- HI and LO are never modified mid-operation; reads always return the last committed values.
- **Reset:** HI=0, LO=0, busy=0, cnt=0, hi_p=lo_p=0, state IDLE. Reset during BUSY discards the pending result.

## Timing
- `start` sampled at edge E0. `busy`=1 from E0+ through E(N) (N = MULT_CYCLES or DIV_CYCLES), i.e. exactly N cycles high.
- HI/LO change at edge E(N), the same edge on which `busy` falls. They are valid in the cycle after the last busy cycle.
- mthi/mtlo: HI/LO update at the sampling edge; latency 1 cycle; `busy` stays 0.
- A new `start` is accepted in the first cycle with `busy`=0, so back-to-back operations are separated by exactly N busy cycles.
- `busy` is a registered output with no combinational path from inputs. HI and LO are registered.
- reset has priority over every other event in the same cycle.

## Test plan
- **multu:** D1=0xFFFFFFFF, D2=2, start pulse.
  - `busy` high exactly 5 cycles.
  - Afterwards HI=0x00000001, LO=0xFFFFFFFE.
  - HI/LO unchanged while busy.
- **mult then div:**
  - mult with D1=0xFFFFFFFD (-3), D2=5 gives HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - Then div with D1=0xFFFFFFF9 (-7), D2=2: `busy` high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Divide corner cases:**
  - Preload HI=0x11111111, LO=0x22222222 via mthi/mtlo. divu with D2=0 runs 10 busy cycles, then HI/LO still 0x11111111/0x22222222.
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **mthi/mtlo timing:**
  - md_op=5, D1=0xABCD1234 in IDLE: HI=0xABCD1234 next cycle, `busy` stays 0.
  - md_op=6 issued while BUSY leaves LO unchanged.
- **Reset mid-operation:** reset asserted in busy cycle 3 of a mult. Next cycle: busy=0, HI=LO=0, and no later commit.
- **Back-to-back:** a second `start` in the same cycle `busy` falls is accepted. A `start` during BUSY is ignored: HI/LO reflect only the first operation, and `busy` does not extend.
